// File: rtl/dcache_if.sv
// Load/store bus between the core, the data cache and word-addressed data memory.
// The cache sits on the slave modport. The core and the memory drive the master side.
interface dcache_if;
  // Core side
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_strb;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  // Memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_strb, mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_strb
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_strb, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_strb
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Read hits are served combinationally. A read miss refills the whole line one beat
// at a time. Every store goes to memory and also updates the line if it is resident.
module dcache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WPL   = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_if.slave     bus,
  output logic [31:0] rd_hit_cnt,
  output logic [31:0] rd_miss_cnt
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 32 - 4 - IW;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t          state;
  logic [LINES-1:0] valid;
  logic [TW-1:0]   tag_arr  [LINES];
  logic [31:0]     data_arr [LINES][WPL];
  logic [1:0]      beat;
  logic            refilled;

  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic [1:0]      req_off;
  logic            hit;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;
  logic            unused_addr_bits;

  // Split the core address. During a refill the line is located from the latched
  // mem_addr, whose index and tag bits stay fixed across all four beats.
  always_comb begin
    req_idx          = bus.cpu_addr[4+IW-1:4];
    req_tag          = bus.cpu_addr[31:4+IW];
    req_off          = bus.cpu_addr[3:2];
    hit              = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    fill_idx         = bus.mem_addr[4+IW-1:4];
    fill_tag         = bus.mem_addr[31:4+IW];
    unused_addr_bits = ^bus.cpu_addr[1:0];
  end

  // Core-facing outputs: hit data and the stall condition.
  always_comb begin
    bus.cpu_rdata = data_arr[req_idx][req_off];
    bus.cpu_stall = ((state == IDLE) && bus.cpu_req && (bus.cpu_we || !hit)) ||
                    (state == REFILL) ||
                    ((state == WRITE) && !bus.mem_ack);
  end

  // Line storage. Only the valid bits are reset. A refill beat and a store merge
  // never happen in the same cycle, because a store is only taken in IDLE.
  always_ff @(posedge clk) begin
    if (state == REFILL && bus.mem_ack) begin
      data_arr[fill_idx][beat] <= bus.mem_rdata;
      if (beat == 2'd3) begin
        tag_arr[fill_idx] <= fill_tag;
      end
    end else if (state == IDLE && bus.cpu_req && bus.cpu_we && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.cpu_strb[b]) begin
          data_arr[req_idx][req_off][8*b +: 8] <= bus.cpu_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered memory-side outputs, valid bits and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      beat          <= 2'd0;
      refilled      <= 1'b0;
      rd_hit_cnt    <= 32'd0;
      rd_miss_cnt   <= 32'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_strb  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            if (bus.cpu_we) begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {bus.cpu_addr[31:2], 2'b00};
              bus.mem_wdata <= bus.cpu_wdata;
              bus.mem_strb  <= bus.cpu_strb;
              state         <= WRITE;
            end else if (hit) begin
              // The first hit after a refill is the retried miss, not a new hit.
              if (refilled) begin
                refilled <= 1'b0;
              end else begin
                rd_hit_cnt <= rd_hit_cnt + 32'd1;
              end
            end else begin
              rd_miss_cnt    <= rd_miss_cnt + 32'd1;
              valid[req_idx] <= 1'b0;
              beat           <= 2'd0;
              bus.mem_req    <= 1'b1;
              bus.mem_we     <= 1'b0;
              bus.mem_addr   <= {bus.cpu_addr[31:4], 4'b0000};
              bus.mem_strb   <= 4'hf;
              state          <= REFILL;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              valid[fill_idx] <= 1'b1;
              refilled        <= 1'b1;
              bus.mem_req     <= 1'b0;
              state           <= IDLE;
            end else begin
              bus.mem_addr <= bus.mem_addr + 32'd4;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed and randomized checks of dcache against a reference memory and a
// line-presence model. It also has a memory responder with random ack latency.
module tb_dcache;
  localparam int unsigned LINES = 16;
  localparam int unsigned IW    = $clog2(LINES);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_if bus ();

  dcache #(.LINES(LINES), .WPL(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rd_hit_cnt  (hit_cnt),
    .rd_miss_cnt (miss_cnt)
  );

  // Memory as seen by the DUT, the reference memory, and the memory transaction log.
  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  txn_t        txlog   [$];
  int unsigned lat_max;

  // Reference cache-presence model and expected counters.
  bit          ref_valid [LINES];
  int unsigned ref_tag   [LINES];
  int unsigned exp_hit, exp_miss;

  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] rd_mem(input int unsigned w);
    if (mem.exists(w)) return mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] rd_ref(input int unsigned w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: it acks each request after 0..lat_max extra cycles.
  initial begin
    int   wait_cnt;
    txn_t t;
    logic [31:0] cur;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    wait_cnt      = -1;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst) begin
        wait_cnt = -1;
      end else if (bus.mem_req) begin
        if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, lat_max));
        if (wait_cnt == 0) begin
          t.we    = bus.mem_we;
          t.addr  = bus.mem_addr;
          t.wdata = bus.mem_wdata;
          t.strb  = bus.mem_strb;
          txlog.push_back(t);
          if (bus.mem_we) begin
            cur = rd_mem(bus.mem_addr >> 2);
            for (int b = 0; b < 4; b++)
              if (bus.mem_strb[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem[bus.mem_addr >> 2] = cur;
          end else begin
            bus.mem_rdata = rd_mem(bus.mem_addr >> 2);
          end
          bus.mem_ack = 1'b1;
          wait_cnt    = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] addr);
    int unsigned idx, tag, cycles, n;
    bit          exp_h;
    logic [31:0] exp_data, got, base;
    @(negedge clk);
    txlog.delete();
    idx      = (addr >> 4) & (LINES - 1);
    tag      = addr >> (4 + IW);
    base     = {addr[31:4], 4'b0000};
    exp_h    = ref_valid[idx] && (ref_tag[idx] == tag);
    exp_data = rd_ref(addr >> 2);
    if (exp_h) begin
      exp_hit++;
    end else begin
      exp_miss++;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr;
    cycles = 1;
    #1;
    while (bus.cpu_stall && cycles < 200) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    chk("ld_stall_released", {31'd0, bus.cpu_stall}, 32'd0);
    got = bus.cpu_rdata;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("ld_data", got, exp_data);
    chk("ld_hit_cnt", hit_cnt, exp_hit);
    chk("ld_miss_cnt", miss_cnt, exp_miss);
    if (lat_max == 0) chk("ld_cycles", cycles, exp_h ? 32'd1 : 32'd6);
    if (exp_h) begin
      chk("ld_hit_txns", txlog.size(), 32'd0);
    end else begin
      chk("ld_miss_txns", txlog.size(), 32'd4);
      n = (txlog.size() < 4) ? txlog.size() : 4;
      for (int i = 0; i < int'(n); i++) begin
        chk("refill_addr", txlog[i].addr, base + 32'(4 * i));
        chk("refill_we", {31'd0, txlog[i].we}, 32'd0);
        chk("refill_strb", {28'd0, txlog[i].strb}, 32'hf);
      end
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int unsigned cycles;
    logic [31:0] cur;
    @(negedge clk);
    txlog.delete();
    cur = rd_ref(addr >> 2);
    for (int b = 0; b < 4; b++)
      if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
    ref_mem[addr >> 2] = cur;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    bus.cpu_strb  = strb;
    cycles = 1;
    #1;
    while (bus.cpu_stall && cycles < 200) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    chk("st_stall_released", {31'd0, bus.cpu_stall}, 32'd0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk("st_txns", txlog.size(), 32'd1);
    if (txlog.size() >= 1) begin
      chk("st_we", {31'd0, txlog[0].we}, 32'd1);
      chk("st_addr", txlog[0].addr, {addr[31:2], 2'b00});
      chk("st_wdata", txlog[0].wdata, data);
      chk("st_strb", {28'd0, txlog[0].strb}, {28'd0, strb});
    end
    chk("st_mem_word", rd_mem(addr >> 2), cur);
    chk("st_hit_cnt", hit_cnt, exp_hit);
    chk("st_miss_cnt", miss_cnt, exp_miss);
    if (lat_max == 0) chk("st_cycles", cycles, 32'd2);
  endtask

  initial begin
    logic        req_before;
    logic [31:0] m0, a;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.cpu_strb  = 4'd0;
    lat_max       = 0;
    exp_hit       = 0;
    exp_miss      = 0;
    for (int i = 0; i < int'(LINES); i++) ref_valid[i] = 1'b0;
    mem[32'hfffc >> 2]     = 32'd0;
    ref_mem[32'hfffc >> 2] = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_strb", {28'd0, bus.mem_strb}, 32'd0);
    chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;

    // Directed sequence with 1-cycle ack
    do_load(32'h9000);
    do_load(32'h9008);
    do_store(32'h9004, 32'hDEADBEEF, 4'b0011);
    do_load(32'h9004);
    chk("merged_word", rd_ref(32'h9004 >> 2), {init_word(32'h9004 >> 2) >> 16, 16'hBEEF});
    do_store(32'hfffc, 32'h000000FF, 4'b0001);
    chk("fffc_word", rd_mem(32'hfffc >> 2), 32'h000000FF);
    do_load(32'hfffc);

    // Reset in the middle of a refill, with variable ack latency
    lat_max = 5;
    @(negedge clk);
    txlog.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h9020;
    repeat (3) @(negedge clk);
    #1;
    req_before = bus.mem_req;
    chk("refill_in_progress", {31'd0, req_before}, 32'd1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    chk("rst_async_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_async_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst_async_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < int'(LINES); i++) ref_valid[i] = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    do_load(32'h9020);

    // Conflict on the same index
    m0 = miss_cnt;
    do_load(32'h9000);
    do_load(32'h9000 + 16 * LINES);
    do_load(32'h9000);
    chk("conflict_misses", miss_cnt - m0, 32'd3);

    // Randomized mix over a few aliasing lines
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0)
        a = 32'hfffc;
      else
        a = 32'h9000 + 16 * LINES * $urandom_range(0, 2) + 4 * $urandom_range(0, 15);
      if ($urandom_range(0, 99) < 35)
        do_store(a, $urandom, 4'($urandom_range(1, 15)));
      else
        do_load(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
